sector_buffer_reader: RTL and testbench

- Downstream consumer of the sector data buffer (DBUFF) that the write digitizer fills.
- After a sector has been written, reads SECTOR_LEN bytes from the buffer read port starting at a latched base address.
- Streams the bytes out over a valid/ready interface and accumulates a 16-bit additive checksum.
- Signals completion with a one-cycle DONE pulse.

---
 rtl/sector_buffer_reader.sv | 140 ++++++++++++++
 tb/tb_sector_buffer_reader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sector_buffer_reader.sv
// Sector buffer reader: fetches SECTOR_LEN bytes from the DBUFF read port starting at a latched
// base address, streams them over valid/ready and accumulates a 16-bit additive checksum.
module sector_buffer_reader #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned SECTOR_LEN = 512
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  output logic [ADDR_W-1:0] RADDR_DBUFF,
  output logic              RDEN_DBUFF,
  input  logic [7:0]        Q_DBUFF,
  output logic [7:0]        OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       CHECKSUM
);

  // One extra count bit so a sector covering the whole address space is representable.
  localparam int unsigned     CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(SECTOR_LEN - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWt, StOut, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [CntW-1:0]   count_q, count_d, count_inc;
  logic              rden_q, rden_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        data_q, data_d;
  logic [15:0]       csum_q, csum_d;

  assign count_inc = count_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    raddr_d = raddr_q;
    count_d = count_q;
    rden_d  = 1'b0;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    csum_d  = csum_q;

    if (ABORT && (state_q != StIdle)) begin
      // Abort wins over every other transition; the partial checksum is kept.
      state_d = StIdle;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (START && !ABORT) begin
            state_d = StRd;
            base_d  = BASE_ADDR;
            raddr_d = BASE_ADDR;
            count_d = '0;
            csum_d  = '0;
            busy_d  = 1'b1;
            rden_d  = 1'b1;
          end
        end
        StRd: begin
          state_d = StWt;
        end
        StWt: begin
          state_d = StOut;
          data_d  = Q_DBUFF;
          valid_d = 1'b1;
          csum_d  = csum_q + {8'h00, Q_DBUFF};
        end
        StOut: begin
          if (OUT_READY) begin
            valid_d = 1'b0;
            count_d = count_inc;
            if (count_q == LastIdx) begin
              state_d = StFin;
              done_d  = 1'b1;
            end else begin
              state_d = StRd;
              rden_d  = 1'b1;
              raddr_d = base_q + count_inc[ADDR_W-1:0];
            end
          end
        end
        StFin: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      base_q  <= '0;
      raddr_q <= '0;
      count_q <= '0;
      rden_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      rden_q  <= rden_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
    end
  end

  assign RADDR_DBUFF = raddr_q;
  assign RDEN_DBUFF  = rden_q;
  assign OUT_DATA    = data_q;
  assign OUT_VALID   = valid_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign CHECKSUM    = csum_q;

endmodule

// File: tb/tb_sector_buffer_reader.sv
// Self-checking bench for sector_buffer_reader: a transaction-level model of the byte stream
// is compared against the DUT every cycle, plus directed literal checks.
module tb_sector_buffer_reader;

  localparam int unsigned AW    = 15;
  localparam int unsigned LEN   = 512;
  localparam int unsigned DEPTH = 1 << AW;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          start, abort, ready, rden, valid, busy, done;
  logic [AW-1:0] base, raddr;
  logic [7:0]    q = 8'h00;
  logic [7:0]    odata;
  logic [15:0]   csum;

  logic          w_start, w_abort, w_ready, w_rden, w_valid, w_busy, w_done;
  logic [AW-1:0] w_base, w_raddr;
  logic [7:0]    w_q = 8'h00;
  logic [7:0]    w_odata;
  logic [15:0]   w_csum;

  logic [7:0] mem [DEPTH];

  sector_buffer_reader #(.ADDR_W(AW), .SECTOR_LEN(LEN)) u_dut (
    .CLK(CLK), .RST(RST), .START(start), .ABORT(abort), .BASE_ADDR(base),
    .RADDR_DBUFF(raddr), .RDEN_DBUFF(rden), .Q_DBUFF(q), .OUT_DATA(odata),
    .OUT_VALID(valid), .OUT_READY(ready), .BUSY(busy), .DONE(done), .CHECKSUM(csum)
  );

  sector_buffer_reader #(.ADDR_W(AW), .SECTOR_LEN(4)) u_wrap (
    .CLK(CLK), .RST(RST), .START(w_start), .ABORT(w_abort), .BASE_ADDR(w_base),
    .RADDR_DBUFF(w_raddr), .RDEN_DBUFF(w_rden), .Q_DBUFF(w_q), .OUT_DATA(w_odata),
    .OUT_VALID(w_valid), .OUT_READY(w_ready), .BUSY(w_busy), .DONE(w_done), .CHECKSUM(w_csum)
  );

  // Registered RAM read ports, one-cycle latency.
  always @(posedge CLK) if (rden) q <= mem[raddr];
  always @(posedge CLK) if (w_rden) w_q <= mem[w_raddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Model state: what the stream must look like, derived from the protocol rules.
  bit            m_active, m_fin, seen_first;
  int            m_idx;
  logic [AW-1:0] m_base;
  logic [15:0]   m_sum;
  logic [7:0]    m_cur;
  bit            p_rden_x, pp_rden_x, p_valid_x, p_ready, p_abort, pp_abort, p_start;
  bit            p_dut_valid;
  logic [AW-1:0] p_base;
  int            start_cyc, first_lat, last_lat, done_cnt;

  always @(negedge CLK) begin : monitor
    bit            hs, st, ab, last, fin_now, exp_rden, exp_rise, exp_valid;
    logic [AW-1:0] a;
    if (!RST) begin
      chk("rst_rden", rden, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", odata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_csum", csum, 0);
      m_active = 0; m_fin = 0; m_idx = 0; m_sum = 0; m_cur = 0; m_base = 0;
      p_rden_x = 0; pp_rden_x = 0; p_valid_x = 0; p_ready = 0; p_abort = 0; pp_abort = 0;
      p_start = 0; p_base = 0; p_dut_valid = 0;
    end else begin
      hs      = p_valid_x && p_ready && !p_abort;
      st      = p_start && !p_abort && !m_active;
      ab      = p_abort && m_active;
      last    = hs && (m_idx == LEN - 1);
      fin_now = 0;
      if (st) begin
        m_active = 1; m_base = p_base; m_idx = 0; m_sum = 0;
        start_cyc = cyc; seen_first = 0; done_cnt = 0;
      end else if (ab) begin
        m_active = 0;
      end else if (m_fin) begin
        m_active = 0;
      end else if (hs) begin
        m_idx++;
        fin_now = last;
      end
      m_fin     = fin_now;
      exp_rden  = st || (hs && !last);
      exp_rise  = pp_rden_x && !pp_abort && !p_abort;
      exp_valid = exp_rise || (p_valid_x && !p_ready && !p_abort);
      a         = m_base + AW'(m_idx);
      if (exp_rise) begin
        m_cur = mem[a];
        m_sum = m_sum + 16'(m_cur);
      end
      chk("rden", rden, exp_rden);
      if (exp_rden) chk("raddr", raddr, a);
      chk("valid", valid, exp_valid);
      if (exp_valid) chk("out_data", odata, m_cur);
      chk("checksum", csum, m_sum);
      chk("done", done, fin_now);
      chk("busy", busy, m_active);
      if (valid && !p_dut_valid && !seen_first) begin
        seen_first = 1;
        first_lat  = cyc - start_cyc;
      end
      if (done) begin
        done_cnt++;
        last_lat = cyc - start_cyc;
      end
      pp_rden_x = p_rden_x; p_rden_x = exp_rden; p_valid_x = exp_valid;
      pp_abort = p_abort; p_abort = abort; p_start = start; p_ready = ready; p_base = base;
      p_dut_valid = valid;
    end
  end

  logic [AW-1:0] w_addrs [$];
  logic [7:0]    w_datas [$];
  always @(negedge CLK) begin
    if (RST) begin
      if (w_rden) w_addrs.push_back(w_raddr);
      if (w_valid && w_ready) w_datas.push_back(w_odata);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    base  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_byte(input int idx, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (valid && m_idx == idx) begin
        ok = 1;
        break;
      end
    end
    chk("wait_byte_timeout", ok, 1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_rden"}, rden, 0);
    chk({pfx, "_raddr"}, raddr, 0);
    chk({pfx, "_valid"}, valid, 0);
    chk({pfx, "_data"}, odata, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_csum"}, csum, 0);
  endtask

  function automatic logic [15:0] sum_bytes(input logic [AW-1:0] b, input int n);
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < n; i++) s = s + 16'(mem[b + AW'(i)]);
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [AW-1:0] b;
    logic [7:0]    d0;
    logic [AW-1:0] ea [4];
    logic [7:0]    ed [4];
    bit            ok;
    int            abort_at;

    RST = 1'b1; start = 0; abort = 0; ready = 0; base = '0;
    w_start = 0; w_abort = 0; w_ready = 1; w_base = '0;
    #1 RST = 1'b0;

    // Reset held with random inputs: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'($urandom); abort = 1'($urandom); ready = 1'($urandom); base = AW'($urandom);
      #1 chk_zero("rst_hold");
    end
    start = 0; abort = 0; ready = 0; base = '0;
    RST = 1'b1;
    repeat (20) tick();
    chk("idle_busy", busy, 0);

    // Full sector with mem[a] = a[7:0].
    for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];
    ready = 1;
    pulse_start('0);
    wait_idle("full_timeout", 2000);
    chk("full_first_valid_cycle", first_lat + 1, 3);
    chk("full_last_hs_cycles", last_lat, 1536);
    chk("full_done_pulses", done_cnt, 1);
    chk("full_checksum", csum, 16'hFF00);
    tick();
    chk("full_busy_after", busy, 0);
    chk("full_checksum_hold", csum, 16'hFF00);

    // Address wrap on the 4-byte instance.
    mem[15'h7FFF] = 8'h11; mem[0] = 8'h22; mem[1] = 8'h33; mem[2] = 8'h44;
    ea = '{15'h7FFF, 15'h0000, 15'h0001, 15'h0002};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    w_addrs.delete(); w_datas.delete();
    w_base = 15'h7FFF; w_start = 1; tick(); w_start = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (!w_busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("wrap_timeout", ok, 1);
    chk("wrap_naddr", w_addrs.size(), 4);
    chk("wrap_ndata", w_datas.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < w_addrs.size()) chk("wrap_raddr", w_addrs[i], ea[i]);
      if (i < w_datas.size()) chk("wrap_data", w_datas[i], ed[i]);
    end
    chk("wrap_checksum", w_csum, 16'h00AA);

    // Backpressure on byte 5.
    fill_random();
    b = AW'($urandom);
    pulse_start(b);
    wait_byte(5, 100);
    ready = 0;
    d0 = odata;
    chk("bp_byte5", d0, mem[b + AW'(5)]);
    repeat (10) begin
      tick();
      chk("bp_valid_held", valid, 1);
      chk("bp_data_held", odata, d0);
      chk("bp_no_rden", rden, 0);
      chk("bp_csum_held", csum, sum_bytes(b, 6));
    end
    ready = 1;
    wait_idle("bp_timeout", 2000);
    chk("bp_checksum", csum, sum_bytes(b, LEN));
    chk("bp_done_pulses", done_cnt, 1);

    // Abort after three handshakes, then restart.
    b = AW'($urandom);
    pulse_start(b);
    wait_byte(3, 100);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rden", rden, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_partial_csum", csum, sum_bytes(b, 4));
    b = AW'($urandom);
    pulse_start(b);
    chk("restart_csum_clear", csum, 0);
    chk("restart_raddr", raddr, b);
    wait_byte(10, 200);
    start = 1; base = AW'($urandom);
    tick();
    start = 0;
    wait_idle("restart_timeout", 2500);
    chk("restart_checksum", csum, sum_bytes(b, LEN));
    chk("restart_done_pulses", done_cnt, 1);

    // Asynchronous reset during WT.
    b = AW'($urandom);
    pulse_start(b);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rden) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("midrst_find_rd", ok, 1);
    tick();
    RST = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) tick();
    RST = 1'b1;
    tick();
    b = AW'($urandom);
    pulse_start(b);
    wait_idle("midrst_timeout", 2000);
    chk("midrst_checksum", csum, sum_bytes(b, LEN));
    chk("midrst_done_pulses", done_cnt, 1);

    // Randomized traffic: random backpressure, stray STARTs, one random abort.
    for (int k = 0; k < 4; k++) begin
      fill_random();
      b = AW'($urandom);
      abort_at = $urandom_range(50, 1500);
      pulse_start(b);
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
        tick();
        if (!busy) begin
          ok = 1;
          break;
        end
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 63) == 0);
        base  = AW'($urandom);
        abort = (k == 2) && (i == abort_at);
      end
      start = 0; abort = 0; ready = 1;
      chk("rand_timeout", ok, 1);
      if (k != 2) chk("rand_checksum", csum, sum_bytes(b, LEN));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
